// File: rtl/ppu_sched_pkg.sv
// Shared definitions for the PPU scheduler: raster defaults, mode codes
// and the state encodings of the raster FSM and the request arbiter.
package ppu_sched_pkg;

  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned ACK_TIMEOUT_DEF = 64;

  // PPU pattern modes
  localparam logic [2:0] MODE_PASS    = 3'd0;
  localparam logic [2:0] MODE_XOR     = 3'd1;
  localparam logic [2:0] MODE_STRIPES = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } main_state_e;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_BUSY = 2'd1,
    A_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ppu_sched_if.sv
// Byte-stream bus between the two requesters, the scheduler and the PPU
// data port. master = scheduler side, slave = requesters/PPU side.
interface ppu_sched_if;
  logic [7:0] req0_data;
  logic       req0_stb;
  logic       req0_ack;
  logic [7:0] req1_data;
  logic       req1_stb;
  logic       req1_ack;
  logic [7:0] ppu_data;
  logic       ppu_stb;
  logic       ppu_ack;

  modport master (
    input  req0_data, req0_stb, req1_data, req1_stb, ppu_ack,
    output req0_ack, req1_ack, ppu_data, ppu_stb
  );

  modport slave (
    output req0_data, req0_stb, req1_data, req1_stb, ppu_ack,
    input  req0_ack, req1_ack, ppu_data, ppu_stb
  );
endinterface

// File: rtl/ppu_rr_arb.sv
// Two-way round-robin arbiter feeding the PPU strobe/ack port, with an
// ack watchdog that drops a byte the PPU never acknowledges.
module ppu_rr_arb
  import ppu_sched_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  ppu_sched_if.master bus,
  output logic        last_grant,
  output logic        err_timeout
);

  localparam int WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  arb_state_e      state_r;
  logic [WD_W-1:0] wd_r;
  logic            pick_s;

  // Select the requester to grant: alternate when both are asking.
  always_comb begin
    pick_s = 1'b0;
    if (bus.req0_stb && bus.req1_stb) begin
      pick_s = ~last_grant;
    end else if (bus.req1_stb) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Grant / wait-for-ack / cool-down sequencer with watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= A_IDLE;
      wd_r         <= '0;
      bus.ppu_data <= 8'd0;
      bus.ppu_stb  <= 1'b0;
      bus.req0_ack <= 1'b0;
      bus.req1_ack <= 1'b0;
      last_grant   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      bus.req0_ack <= 1'b0;
      bus.req1_ack <= 1'b0;
      case (state_r)
        A_IDLE: begin
          if (run && (bus.req0_stb || bus.req1_stb)) begin
            bus.ppu_data <= pick_s ? bus.req1_data : bus.req0_data;
            bus.ppu_stb  <= 1'b1;
            last_grant   <= pick_s;
            wd_r         <= '0;
            state_r      <= A_BUSY;
          end
        end
        A_BUSY: begin
          // An ack on the final watchdog cycle still counts as delivered.
          if (bus.ppu_ack || (wd_r == WD_LAST)) begin
            bus.ppu_stb <= 1'b0;
            if (last_grant) begin
              bus.req1_ack <= 1'b1;
            end else begin
              bus.req0_ack <= 1'b1;
            end
            if (!bus.ppu_ack) begin
              err_timeout <= 1'b1;
            end
            state_r <= A_DONE;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        A_DONE: begin
          // Requester still shows the acked strobe this cycle; skip it.
          state_r <= A_IDLE;
        end
        default: begin
          state_r <= A_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ppu_sched.sv
// PPU scheduler: raster counter aligned to the PPU via sync_o, mode
// changes applied only at frame boundaries, and the byte arbiter.
module ppu_sched
  import ppu_sched_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  mode_req,
  input  logic        mode_req_vld,
  output logic [2:0]  mode,
  output logic        sync_o,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  ppu_sched_if.master bus,
  output logic        last_grant,
  output logic        err_timeout
);

  localparam int HX_W = $clog2(H_TOTAL);
  localparam int VY_W = $clog2(V_TOTAL);
  localparam logic [HX_W-1:0] HX_LAST = HX_W'(H_TOTAL - 1);
  localparam logic [VY_W-1:0] VY_LAST = VY_W'(V_TOTAL - 1);

  main_state_e     state_r;
  logic [HX_W-1:0] hx_r;
  logic [VY_W-1:0] vy_r;
  logic [2:0]      pending_r;
  logic            run_s;

  assign run_s = (state_r == RUN);

  // Pending mode: last strobe before a frame boundary wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= MODE_PASS;
    end else if (mode_req_vld) begin
      pending_r <= mode_req;
    end
  end

  // Raster FSM: idle, one-cycle alignment with the PPU, then free-running raster.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hx_r        <= '0;
      vy_r        <= '0;
      mode        <= MODE_PASS;
      sync_o      <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      sync_o      <= 1'b0;
      frame_start <= 1'b0;
      case (state_r)
        IDLE: begin
          hx_r <= '0;
          vy_r <= '0;
          if (enable) begin
            state_r <= ALIGN;
          end
        end
        ALIGN: begin
          mode    <= pending_r;
          sync_o  <= 1'b1;
          state_r <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state_r <= IDLE;
            hx_r    <= '0;
            vy_r    <= '0;
          end else if (hx_r == HX_LAST) begin
            hx_r <= '0;
            if (vy_r == VY_LAST) begin
              // Frame end: pending_r here is the value before any same-cycle strobe.
              vy_r        <= '0;
              mode        <= pending_r;
              frame_cnt   <= frame_cnt + 16'd1;
              frame_start <= 1'b1;
            end else begin
              vy_r <= vy_r + VY_W'(1);
            end
          end else begin
            hx_r <= hx_r + HX_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  ppu_rr_arb #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run_s),
    .bus         (bus),
    .last_grant  (last_grant),
    .err_timeout (err_timeout)
  );

endmodule
